csm_datapath: RTL and testbench

- Arithmetic/stack datapath of the uCode stack machine.
- Bundles three units that share one clock and reset:
  - a combinational 16-op ALU;
  - a return stack with push/pop controls (R);
  - an evaluation stack driven by a 3-bit stack-effect code (D).
- The surrounding control sequencer selects ALU operands and feeds ALU/memory results back into the stacks.

---
 rtl/csm_datapath_if.sv | 33 +++
 rtl/csm_datapath.sv | 133 +++++++++++++
 tb/tb_csm_datapath.sv | 308 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/csm_datapath_if.sv
// Bus bundle for the stack-machine datapath: ALU operands/result, D-stack effect, R-stack push/pop.
// Signal names keep the datapath's i_/o_ port naming as seen from the datapath (slave) side.
interface csm_datapath_if #(
    parameter int WIDTH = 16
);
    // No valid/ready handshake: every input is sampled on each rising edge; i_d_se=0 with
    // i_r_push/i_r_pop low is the idle cycle, and outputs are always valid.
    logic [3:0]       i_alu_op;
    logic [WIDTH-1:0] i_alu_arg0;
    logic [WIDTH-1:0] i_alu_arg1;
    logic [WIDTH-1:0] o_alu_data;
    logic [WIDTH-1:0] i_d_data;
    logic [2:0]       i_d_se;
    logic [WIDTH-1:0] o_d0;
    logic [WIDTH-1:0] o_d1;
    logic [WIDTH-1:0] i_r_data;
    logic             i_r_push;
    logic             i_r_pop;
    logic [WIDTH-1:0] o_r0;
    logic [WIDTH-1:0] o_r1;

    modport master (
        output i_alu_op, i_alu_arg0, i_alu_arg1, i_d_data, i_d_se,
               i_r_data, i_r_push, i_r_pop,
        input  o_alu_data, o_d0, o_d1, o_r0, o_r1
    );

    modport slave (
        input  i_alu_op, i_alu_arg0, i_alu_arg1, i_d_data, i_d_se,
               i_r_data, i_r_push, i_r_pop,
        output o_alu_data, o_d0, o_d1, o_r0, o_r1
    );
endinterface

// File: rtl/csm_datapath.sv
// Stack-machine datapath: combinational 16-op ALU, shift-register evaluation stack (D)
// driven by a 3-bit stack-effect code, and shift-register return stack (R).
module csm_datapath #(
    parameter int WIDTH   = 16,
    parameter int D_DEPTH = 12,
    parameter int R_DEPTH = 12
) (
    input  logic            i_clk,
    input  logic            i_rst,
    csm_datapath_if.slave   bus
);
    localparam logic [3:0] OP_PASS = 4'h0, OP_ADD  = 4'h1, OP_SUB  = 4'h2, OP_MUL  = 4'h3,
                           OP_AND  = 4'h4, OP_XOR  = 4'h5, OP_OR   = 4'h6, OP_ROL1 = 4'h7,
                           OP_ROL2 = 4'h8, OP_ROL4 = 4'h9, OP_ROL8 = 4'hA, OP_ASR1 = 4'hB,
                           OP_ASR2 = 4'hC, OP_ASR4 = 4'hD, OP_ASR8 = 4'hE;

    localparam logic [2:0] SE_NONE = 3'd0, SE_DROP = 3'd1, SE_PUSH = 3'd2, SE_RPLC = 3'd3,
                           SE_SWAP = 3'd4, SE_ROT  = 3'd5, SE_NROT = 3'd6, SE_ALU2 = 3'd7;

    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] alu_res;

    assign a = bus.i_alu_arg0;
    assign b = bus.i_alu_arg1;

    // Op F (memory op) and PASS both return a; the sequencer bypasses the ALU for F.
    always_comb begin
        alu_res = a;
        case (bus.i_alu_op)
            OP_PASS: alu_res = a;
            OP_ADD:  alu_res = a + b;
            OP_SUB:  alu_res = a - b;
            OP_MUL:  alu_res = a * b;
            OP_AND:  alu_res = a & b;
            OP_XOR:  alu_res = a ^ b;
            OP_OR:   alu_res = a | b;
            OP_ROL1: alu_res = {a[WIDTH-2:0], a[WIDTH-1]};
            OP_ROL2: alu_res = {a[WIDTH-3:0], a[WIDTH-1:WIDTH-2]};
            OP_ROL4: alu_res = {a[WIDTH-5:0], a[WIDTH-1:WIDTH-4]};
            OP_ROL8: alu_res = {a[WIDTH-9:0], a[WIDTH-1:WIDTH-8]};
            OP_ASR1: alu_res = $unsigned($signed(a) >>> 1);
            OP_ASR2: alu_res = $unsigned($signed(a) >>> 2);
            OP_ASR4: alu_res = $unsigned($signed(a) >>> 4);
            OP_ASR8: alu_res = $unsigned($signed(a) >>> 8);
            default: alu_res = a;
        endcase
    end

    assign bus.o_alu_data = alu_res;

    logic [WIDTH-1:0] d_s   [D_DEPTH];
    logic [WIDTH-1:0] d_nxt [D_DEPTH];

    always_comb begin
        d_nxt = d_s;
        case (bus.i_d_se)
            SE_NONE: d_nxt = d_s;
            SE_DROP: begin
                for (int i = 0; i < D_DEPTH - 1; i++) d_nxt[i] = d_s[i+1];
                d_nxt[D_DEPTH-1] = '0;
            end
            SE_PUSH: begin
                d_nxt[0] = bus.i_d_data;
                for (int i = 1; i < D_DEPTH; i++) d_nxt[i] = d_s[i-1];
            end
            SE_RPLC: d_nxt[0] = bus.i_d_data;
            SE_SWAP: begin
                d_nxt[0] = d_s[1];
                d_nxt[1] = d_s[0];
            end
            SE_ROT: begin
                d_nxt[0] = d_s[2];
                d_nxt[1] = d_s[0];
                d_nxt[2] = d_s[1];
            end
            SE_NROT: begin
                d_nxt[0] = d_s[1];
                d_nxt[1] = d_s[2];
                d_nxt[2] = d_s[0];
            end
            SE_ALU2: begin
                // Binary op consumes two operands and pushes one result.
                d_nxt[0] = bus.i_d_data;
                for (int i = 1; i < D_DEPTH - 1; i++) d_nxt[i] = d_s[i+1];
                d_nxt[D_DEPTH-1] = '0;
            end
            default: d_nxt = d_s;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < D_DEPTH; i++) d_s[i] <= '0;
        end else begin
            d_s <= d_nxt;
        end
    end

    assign bus.o_d0 = d_s[0];
    assign bus.o_d1 = d_s[1];

    logic [WIDTH-1:0] r_s   [R_DEPTH];
    logic [WIDTH-1:0] r_nxt [R_DEPTH];

    // Push together with pop collapses to a replace of the top entry.
    always_comb begin
        r_nxt = r_s;
        case ({bus.i_r_push, bus.i_r_pop})
            2'b10: begin
                r_nxt[0] = bus.i_r_data;
                for (int i = 1; i < R_DEPTH; i++) r_nxt[i] = r_s[i-1];
            end
            2'b01: begin
                for (int i = 0; i < R_DEPTH - 1; i++) r_nxt[i] = r_s[i+1];
                r_nxt[R_DEPTH-1] = '0;
            end
            2'b11:   r_nxt[0] = bus.i_r_data;
            default: r_nxt = r_s;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < R_DEPTH; i++) r_s[i] <= '0;
        end else begin
            r_s <= r_nxt;
        end
    end

    assign bus.o_r0 = r_s[0];
    assign bus.o_r1 = r_s[1];
endmodule

// File: tb/tb_csm_datapath.sv
// Self-checking bench for csm_datapath: directed scenarios plus random ALU ops and random
// stack effects compared against a queue-based stack model and an arithmetic ALU model.
module tb_csm_datapath;
  localparam int W  = 16;
  localparam int DD = 12;
  localparam int RD = 12;

  logic i_clk = 1'b0;
  logic i_rst;

  always #5 i_clk = ~i_clk;

  csm_datapath_if #(.WIDTH(W)) bus ();

  csm_datapath #(.WIDTH(W), .D_DEPTH(DD), .R_DEPTH(RD)) dut (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Scoreboard: model stacks, index 0 is the top entry, always kept at full depth.
  logic [W-1:0] d_exp_q[$];
  logic [W-1:0] r_exp_q[$];

  function automatic logic [W-1:0] alu_ref(input logic [3:0] op, input logic [W-1:0] a,
                                           input logic [W-1:0] b);
    longint ia, ib, sa, r;
    ia = longint'(a);
    ib = longint'(b);
    sa = a[W-1] ? ia - 65536 : ia;
    case (op)
      4'h1: r = ia + ib;
      4'h2: r = ia - ib;
      4'h3: r = ia * ib;
      4'h4: r = ia & ib;
      4'h5: r = ia ^ ib;
      4'h6: r = ia | ib;
      4'h7: r = (ia << 1) | (ia >> (W - 1));
      4'h8: r = (ia << 2) | (ia >> (W - 2));
      4'h9: r = (ia << 4) | (ia >> (W - 4));
      4'hA: r = (ia << 8) | (ia >> (W - 8));
      4'hB: r = sa >>> 1;
      4'hC: r = sa >>> 2;
      4'hD: r = sa >>> 4;
      4'hE: r = sa >>> 8;
      default: r = ia;
    endcase
    return r[W-1:0];
  endfunction

  task automatic model_clear();
    d_exp_q = {};
    r_exp_q = {};
    repeat (DD) d_exp_q.push_back('0);
    repeat (RD) r_exp_q.push_back('0);
  endtask

  task automatic model_step(input logic [2:0] se, input logic [W-1:0] dd, input logic push,
                            input logic pop, input logic [W-1:0] rd);
    logic [W-1:0] t;
    case (se)
      3'd1: begin void'(d_exp_q.pop_front()); d_exp_q.push_back('0); end
      3'd2: begin d_exp_q.push_front(dd); void'(d_exp_q.pop_back()); end
      3'd3: d_exp_q[0] = dd;
      3'd4: begin t = d_exp_q[0]; d_exp_q[0] = d_exp_q[1]; d_exp_q[1] = t; end
      3'd5: begin t = d_exp_q[2]; d_exp_q.delete(2); d_exp_q.push_front(t); end
      3'd6: begin t = d_exp_q[0]; d_exp_q.delete(0); d_exp_q.insert(2, t); end
      3'd7: begin
        void'(d_exp_q.pop_front());
        void'(d_exp_q.pop_front());
        d_exp_q.push_front(dd);
        d_exp_q.push_back('0);
      end
      default: ;
    endcase
    if (push && pop) r_exp_q[0] = rd;
    else if (push) begin r_exp_q.push_front(rd); void'(r_exp_q.pop_back()); end
    else if (pop) begin void'(r_exp_q.pop_front()); r_exp_q.push_back('0); end
  endtask

  // Driver: called at a falling edge, applies one effect on the next rising edge,
  // returns at the following falling edge with effects idle.
  task automatic drive_cycle(input logic [2:0] se, input logic [W-1:0] dd, input logic push,
                             input logic pop, input logic [W-1:0] rd);
    bus.i_d_se   = se;
    bus.i_d_data = dd;
    bus.i_r_push = push;
    bus.i_r_pop  = pop;
    bus.i_r_data = rd;
    @(posedge i_clk);
    model_step(se, dd, push, pop, rd);
    @(negedge i_clk);
    bus.i_d_se   = 3'd0;
    bus.i_r_push = 1'b0;
    bus.i_r_pop  = 1'b0;
  endtask

  task automatic pulse_reset();
    i_rst = 1'b1;
    #2;
    i_rst = 1'b0;
    model_clear();
    @(negedge i_clk);
  endtask

  task automatic test_reset();
    i_rst = 1'b1;
    repeat (2) @(negedge i_clk);
    n_checks++;
    if ({bus.o_d0, bus.o_d1, bus.o_r0, bus.o_r1} !== '0) begin
      n_fail++;
      $display("FAIL rst_init got d0=%h d1=%h r0=%h r1=%h exp all 0",
               bus.o_d0, bus.o_d1, bus.o_r0, bus.o_r1);
    end
    i_rst = 1'b0;
    model_clear();
    drive_cycle(3'd2, 16'hAAAA, 1'b1, 1'b0, 16'h5555);
    drive_cycle(3'd2, 16'h1234, 1'b1, 1'b0, 16'h4321);
    n_checks++;
    if (bus.o_d0 !== 16'h1234 || bus.o_d1 !== 16'hAAAA || bus.o_r0 !== 16'h4321 ||
        bus.o_r1 !== 16'h5555) begin
      n_fail++;
      $display("FAIL rst_preload got d0=%h d1=%h r0=%h r1=%h exp 1234 aaaa 4321 5555",
               bus.o_d0, bus.o_d1, bus.o_r0, bus.o_r1);
    end
    // Asynchronous clear observed between edges, before any rising edge.
    i_rst = 1'b1;
    #2;
    n_checks++;
    if ({bus.o_d0, bus.o_d1, bus.o_r0, bus.o_r1} !== '0) begin
      n_fail++;
      $display("FAIL rst_async got d0=%h d1=%h r0=%h r1=%h exp all 0",
               bus.o_d0, bus.o_d1, bus.o_r0, bus.o_r1);
    end
    i_rst = 1'b0;
    model_clear();
    @(negedge i_clk);
  endtask

  task automatic test_alu();
    logic [3:0]   ops [11] = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'hB, 4'h6, 4'h0, 4'hF};
    logic [W-1:0] as  [11] = '{16'h0005, 16'h0005, 16'h0005, 16'h0005, 16'h0005, 16'h0005,
                               16'h8001, 16'h8001, 16'h0000, 16'h1234, 16'hBEEF};
    logic [W-1:0] bs  [11] = '{16'h0003, 16'h0003, 16'h0003, 16'h0003, 16'h0003, 16'h0003,
                               16'h0000, 16'h0000, 16'hFFFF, 16'h5555, 16'h1111};
    logic [W-1:0] exs [11] = '{16'h0008, 16'h0002, 16'h000F, 16'h0001, 16'h0006, 16'h0007,
                               16'h0003, 16'hC000, 16'hFFFF, 16'h1234, 16'hBEEF};
    logic [W-1:0] exp_v;
    for (int i = 0; i < 11; i++) begin
      bus.i_alu_op   = ops[i];
      bus.i_alu_arg0 = as[i];
      bus.i_alu_arg1 = bs[i];
      #1;
      n_checks++;
      if (bus.o_alu_data !== exs[i]) begin
        n_fail++;
        $display("FAIL alu_dir op=%h a=%h b=%h got %h exp %h",
                 ops[i], as[i], bs[i], bus.o_alu_data, exs[i]);
      end
    end
    for (int i = 0; i < 400; i++) begin
      bus.i_alu_op   = 4'(i % 16);
      bus.i_alu_arg0 = W'($urandom_range(0, 65535));
      bus.i_alu_arg1 = W'($urandom_range(0, 65535));
      #1;
      exp_v = alu_ref(bus.i_alu_op, bus.i_alu_arg0, bus.i_alu_arg1);
      n_checks++;
      if (bus.o_alu_data !== exp_v) begin
        n_fail++;
        $display("FAIL alu_rand op=%h a=%h b=%h got %h exp %h",
                 bus.i_alu_op, bus.i_alu_arg0, bus.i_alu_arg1, bus.o_alu_data, exp_v);
      end
    end
    @(negedge i_clk);
  endtask

  task automatic test_d_effects();
    logic [2:0]   se_t [8] = '{3'd2, 3'd2, 3'd2, 3'd5, 3'd4, 3'd4, 3'd6, 3'd7};
    logic [W-1:0] dd_t [8] = '{16'd1, 16'd2, 16'd3, 16'd0, 16'd0, 16'd0, 16'd0, 16'd5};
    logic [W-1:0] e0_t [8] = '{16'd1, 16'd2, 16'd3, 16'd1, 16'd3, 16'd1, 16'd3, 16'd5};
    logic [W-1:0] e1_t [8] = '{16'd0, 16'd1, 16'd2, 16'd3, 16'd1, 16'd3, 16'd2, 16'd1};
    pulse_reset();
    for (int i = 0; i < 8; i++) begin
      drive_cycle(se_t[i], dd_t[i], 1'b0, 1'b0, '0);
      n_checks++;
      if (bus.o_d0 !== e0_t[i] || bus.o_d1 !== e1_t[i]) begin
        n_fail++;
        $display("FAIL d_effect step=%0d se=%0d got d0=%h d1=%h exp d0=%h d1=%h",
                 i, se_t[i], bus.o_d0, bus.o_d1, e0_t[i], e1_t[i]);
      end
    end
    drive_cycle(3'd3, 16'h0077, 1'b0, 1'b0, '0);
    n_checks++;
    if (bus.o_d0 !== 16'h0077 || bus.o_d1 !== 16'd1) begin
      n_fail++;
      $display("FAIL d_rplc got d0=%h d1=%h exp 0077 0001", bus.o_d0, bus.o_d1);
    end
  endtask

  task automatic test_d_overflow();
    pulse_reset();
    for (int v = 1; v <= 13; v++) drive_cycle(3'd2, W'(v), 1'b0, 1'b0, '0);
    for (int i = 0; i < 12; i++) begin
      n_checks++;
      if (bus.o_d0 !== W'(13 - i)) begin
        n_fail++;
        $display("FAIL d_ovf_read idx=%0d got %h exp %h", i, bus.o_d0, W'(13 - i));
      end
      drive_cycle(3'd1, '0, 1'b0, 1'b0, '0);
    end
    n_checks++;
    if (bus.o_d0 !== '0 || bus.o_d1 !== '0) begin
      n_fail++;
      $display("FAIL d_ovf_empty got d0=%h d1=%h exp 0 0", bus.o_d0, bus.o_d1);
    end
    drive_cycle(3'd1, '0, 1'b0, 1'b0, '0);
    n_checks++;
    if (bus.o_d0 !== '0) begin
      n_fail++;
      $display("FAIL d_underflow got %h exp 0", bus.o_d0);
    end
  endtask

  task automatic test_r_stack();
    pulse_reset();
    drive_cycle(3'd0, '0, 1'b1, 1'b0, 16'h0100);
    drive_cycle(3'd0, '0, 1'b1, 1'b0, 16'h0200);
    n_checks++;
    if (bus.o_r0 !== 16'h0200 || bus.o_r1 !== 16'h0100) begin
      n_fail++;
      $display("FAIL r_push got r0=%h r1=%h exp 0200 0100", bus.o_r0, bus.o_r1);
    end
    drive_cycle(3'd0, '0, 1'b1, 1'b1, 16'h0300);
    n_checks++;
    if (bus.o_r0 !== 16'h0300 || bus.o_r1 !== 16'h0100) begin
      n_fail++;
      $display("FAIL r_replace got r0=%h r1=%h exp 0300 0100", bus.o_r0, bus.o_r1);
    end
    drive_cycle(3'd0, '0, 1'b0, 1'b1, '0);
    n_checks++;
    if (bus.o_r0 !== 16'h0100) begin
      n_fail++;
      $display("FAIL r_pop got %h exp 0100", bus.o_r0);
    end
    drive_cycle(3'd0, '0, 1'b0, 1'b1, '0);
    drive_cycle(3'd0, '0, 1'b0, 1'b1, '0);
    n_checks++;
    if (bus.o_r0 !== '0 || bus.o_r1 !== '0) begin
      n_fail++;
      $display("FAIL r_underflow got r0=%h r1=%h exp 0 0", bus.o_r0, bus.o_r1);
    end
  endtask

  task automatic test_simultaneous();
    pulse_reset();
    drive_cycle(3'd2, 16'h0011, 1'b1, 1'b0, 16'h0A0A);
    drive_cycle(3'd0, '0, 1'b1, 1'b0, 16'h0B0B);
    drive_cycle(3'd2, 16'h0022, 1'b0, 1'b1, '0);
    n_checks++;
    if (bus.o_d0 !== 16'h0022 || bus.o_d1 !== 16'h0011 || bus.o_r0 !== 16'h0A0A ||
        bus.o_r1 !== 16'h0000) begin
      n_fail++;
      $display("FAIL simul got d0=%h d1=%h r0=%h r1=%h exp 0022 0011 0a0a 0000",
               bus.o_d0, bus.o_d1, bus.o_r0, bus.o_r1);
    end
  endtask

  task automatic test_random_stacks();
    pulse_reset();
    for (int i = 0; i < 400; i++) begin
      drive_cycle(3'($urandom_range(0, 7)), W'($urandom_range(0, 65535)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  W'($urandom_range(0, 65535)));
      n_checks++;
      if (bus.o_d0 !== d_exp_q[0] || bus.o_d1 !== d_exp_q[1] ||
          bus.o_r0 !== r_exp_q[0] || bus.o_r1 !== r_exp_q[1]) begin
        n_fail++;
        $display("FAIL rand_stack cyc=%0d got d0=%h d1=%h r0=%h r1=%h exp %h %h %h %h",
                 i, bus.o_d0, bus.o_d1, bus.o_r0, bus.o_r1,
                 d_exp_q[0], d_exp_q[1], r_exp_q[0], r_exp_q[1]);
      end
    end
  endtask

  initial begin
    bus.i_alu_op   = '0;
    bus.i_alu_arg0 = '0;
    bus.i_alu_arg1 = '0;
    bus.i_d_data   = '0;
    bus.i_d_se     = '0;
    bus.i_r_data   = '0;
    bus.i_r_push   = 1'b0;
    bus.i_r_pop    = 1'b0;
    model_clear();
    test_reset();
    test_alu();
    test_d_effects();
    test_d_overflow();
    test_r_stack();
    test_simultaneous();
    test_random_stacks();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
